divider_controller: RTL
=======================

# divider_controller

Sequencing FSM for the 10-bit fixed-point restoring-divider datapath.
- Accepts a start request and captures both operands into the datapath.
- Runs the shift/compare/subtract iterations, paced by the datapath's 4-bit iteration counter.
- Reports completion, divide-by-zero and overflow to the requester.
- Sits between the bus-side requester and the divider datapath, driving every load/select/enable input of the datapath.

## Interface
- DONE_CYCLES, default 1: cycles `done` is held high in DONE state; legal 1–15.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE; operands must be valid on the datapath inputs in the same cycle
- dvz  in  1  datapath divide-by-zero flag (combinational from divisor input)
- ovf  in  1  datapath overflow flag
- carry_out  in  1  datapath counter terminal flag (counter == 15)
- load_a, load_b  out  1  operand register loads
- load_Q, load_Q_next, load_acc, load_acc_next  out  1  quotient/accumulator register loads
- load_counter, enable_counter  out  1  iteration counter load (to 1) / increment
- sel_Q, sel_acc  out  1  0 = initial value from dividend, 1 = iterate from *_next
- sel_dvz  out  1  forces compare operand to zero; equals err_dvz
- busy  out  1  high in every state except IDLE
- done  out  1  result/flags valid
- err_dvz, err_ovf  out  1  sticky status, cleared on next accepted start

## Operation
- States: IDLE, INIT, SHIFT, UPDATE, DONE.
- All datapath control outputs are decoded from the state, plus `start` in IDLE. Any control not listed for a state is 0.
- IDLE:
  - On `start` = 1: assert load_a = load_b = 1 this cycle and clear err_ovf.
  - If `dvz` = 1: set err_dvz and go to DONE.
  - Otherwise: clear err_dvz and go to INIT.
- INIT: sel_Q = 0, load_Q = 1, sel_acc = 0, load_acc = 1, load_counter = 1; then go to SHIFT.
- SHIFT: load_Q_next = 1, load_acc_next = 1; then go to UPDATE.
- UPDATE: sel_Q = 1, load_Q = 1, sel_acc = 1, load_acc = 1.
  - If `ovf` = 1: set err_ovf.
  - If carry_out = 1: go to DONE.
  - Otherwise: enable_counter = 1 and go to SHIFT.
- DONE: done = 1 for DONE_CYCLES cycles (internal 4-bit hold counter), then go to IDLE.
- `start` outside IDLE is ignored; no queuing.
- The counter is loaded with 1 and terminates at 15, giving exactly 15 SHIFT/UPDATE iterations.
- Divide-by-zero skips INIT/SHIFT/UPDATE entirely. Q and acc hold their previous contents; load_Q is never asserted.
- err_dvz and err_ovf hold their values through IDLE until the next accepted start.

## Timing
- Reset (asynchronous):
  - State goes to IDLE.
  - busy, done, err_dvz, err_ovf, sel_dvz and all load/enable/select outputs go to 0.
  - Hold counter goes to 0.
- Reset mid-operation abandons the division with no done pulse. Datapath contents are don't-care.
- Cycle 0 is the IDLE cycle in which start is accepted; operands are captured at its closing edge.
- Normal path:
  - INIT at cycle 1.
  - SHIFT at cycles 2, 4, …, 30; UPDATE at cycles 3, 5, …, 31.
  - done first high at cycle 32; busy falls when DONE exits.
  - A new start is accepted at cycle 32 + DONE_CYCLES.
- DVZ path: done first high at cycle 1.
- ovf sampled in UPDATE: ovf and carry_out both high in the same UPDATE sets err_ovf and goes to DONE.
- carry_out in any state other than UPDATE is ignored.

## Configuration
- DIV_OVF_ABORT_EN defined:
  - ovf = 1 in UPDATE sets err_ovf and goes directly to DONE, with no enable_counter that cycle.
  - done then arrives early; Q holds the partial quotient.
- Not defined: ovf only sets err_ovf, and all 15 iterations always complete.

## Test plan
- a = 10'd300, b = 10'd12, start pulse at cycle 0:
  - load_a = load_b = 1 at cycle 0, load_counter = 1 at cycle 1.
  - 15 load_Q_next pulses.
  - done = 1 at cycle 32 for DONE_CYCLES cycles; err_dvz = err_ovf = 0.
  - Q matches golden model.
- b = 0, start:
  - err_dvz = 1, sel_dvz = 1, done = 1 at cycle 1.
  - load_Q never asserted; busy low by cycle 1 + DONE_CYCLES.
- Overflow (a = 10'd1023, b = 10'd1), ovf forced at the 10th UPDATE:
  - err_ovf = 1.
  - With DIV_OVF_ABORT_EN: done at cycle 22. Without: done at cycle 32.
- Reset asserted at cycle 10, mid-division:
  - All outputs 0 asynchronously; no done pulse.
  - Next start after reset release runs the full 32-cycle sequence.
- start held high continuously:
  - Second division accepted exactly at cycle 32 + DONE_CYCLES.
  - err flags from run 1 cleared at that acceptance; no extra load_a pulses while busy.
- DONE_CYCLES = 3: done high at cycles 32–34, busy low at cycle 35.

Source files
------------

// File: rtl/divider_controller.sv
// Sequencing FSM for the 10-bit restoring divider: operand capture, 15 shift/update iterations, done/status.
// Optional DIV_OVF_ABORT_EN: an overflow seen in UPDATE ends the division immediately.
module divider_controller #(
  parameter int DONE_CYCLES = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_dvz,
  input  logic i_ovf,
  input  logic i_carry_out,
  output logic o_load_a,
  output logic o_load_b,
  output logic o_load_Q,
  output logic o_load_Q_next,
  output logic o_load_acc,
  output logic o_load_acc_next,
  output logic o_load_counter,
  output logic o_enable_counter,
  output logic o_sel_Q,
  output logic o_sel_acc,
  output logic o_sel_dvz,
  output logic o_busy,
  output logic o_done,
  output logic o_err_dvz,
  output logic o_err_ovf
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    SHIFT  = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(DONE_CYCLES - 1);
`ifdef DIV_OVF_ABORT_EN
  localparam logic OVF_ABORT = 1'b1;
`else
  localparam logic OVF_ABORT = 1'b0;
`endif

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_hold;
  logic       r_load_q, r_load_q_next, r_load_acc, r_load_acc_next, r_load_counter;
  logic       r_sel_q, r_sel_acc, r_busy, r_done, r_err_dvz, r_err_ovf;
  logic       w_accept;
  logic       w_leave_update;

  // The request must be acted on in the cycle it is sampled, so the operand
  // loads and the counter step are the only outputs not taken from a register.
  assign w_accept       = (r_state == IDLE) && i_start && !i_rst;
  assign w_leave_update = i_carry_out || (OVF_ABORT && i_ovf);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_next = i_dvz ? DONE : INIT;
      INIT:    w_state_next = SHIFT;
      SHIFT:   w_state_next = UPDATE;
      UPDATE:  w_state_next = w_leave_update ? DONE : SHIFT;
      DONE:    if (r_hold == HOLD_LAST) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Registered controls are decoded from the state being entered so they are
  // valid for the whole of that state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= IDLE;
      r_hold          <= 4'd0;
      r_load_q        <= 1'b0;
      r_load_q_next   <= 1'b0;
      r_load_acc      <= 1'b0;
      r_load_acc_next <= 1'b0;
      r_load_counter  <= 1'b0;
      r_sel_q         <= 1'b0;
      r_sel_acc       <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_err_dvz       <= 1'b0;
      r_err_ovf       <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_hold          <= (r_state == DONE && w_state_next == DONE) ? r_hold + 4'd1 : 4'd0;
      r_load_q        <= (w_state_next == INIT) || (w_state_next == UPDATE);
      r_load_acc      <= (w_state_next == INIT) || (w_state_next == UPDATE);
      r_sel_q         <= (w_state_next == UPDATE);
      r_sel_acc       <= (w_state_next == UPDATE);
      r_load_q_next   <= (w_state_next == SHIFT);
      r_load_acc_next <= (w_state_next == SHIFT);
      r_load_counter  <= (w_state_next == INIT);
      r_busy          <= (w_state_next != IDLE);
      r_done          <= (w_state_next == DONE);
      if (r_state == IDLE && i_start) begin
        r_err_ovf <= 1'b0;
        r_err_dvz <= i_dvz;
      end else if (r_state == UPDATE && i_ovf) begin
        r_err_ovf <= 1'b1;
      end
    end
  end

  assign o_load_a         = w_accept;
  assign o_load_b         = w_accept;
  assign o_enable_counter = (r_state == UPDATE) && !w_leave_update;
  assign o_load_Q         = r_load_q;
  assign o_load_Q_next    = r_load_q_next;
  assign o_load_acc       = r_load_acc;
  assign o_load_acc_next  = r_load_acc_next;
  assign o_load_counter   = r_load_counter;
  assign o_sel_Q          = r_sel_q;
  assign o_sel_acc        = r_sel_acc;
  assign o_sel_dvz        = r_err_dvz;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_err_dvz        = r_err_dvz;
  assign o_err_ovf        = r_err_ovf;

endmodule
